// File: rtl/bf_pointer_unit.sv
// Data-pointer unit for the brainfuck core: run-length pointer moves, direct
// load/clear, and the [>] / [<] scan idioms driven by data-memory reads.
module bf_pointer_unit #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 8,
  parameter bit          WRAP   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_arg,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_DEC    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_SCAN_R = 3'd5;
  localparam logic [2:0] OP_SCAN_L = 3'd6;

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              left_q, left_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              err_set;

  // Shared step datapath: the command argument in IDLE, a unit step in SCAN.
  logic              step_dec;
  logic [ADDR_W-1:0] step_arg;
  logic [ADDR_W:0]   arg_ext, addr_ext, sum_w, cnt_inc;
  logic              arg_big, step_oob, step_err;
  logic [ADDR_W-1:0] step_res;

  always_comb begin
    step_dec = (state_q == ST_SCAN) ? left_q : (cmd_op == OP_DEC);
    step_arg = (state_q == ST_SCAN) ? ADDR_W'(1) : cmd_arg;
    arg_ext  = {1'b0, step_arg};
    addr_ext = {1'b0, addr_q};
    sum_w    = addr_ext + arg_ext;
    arg_big  = (arg_ext >= DEPTH_W);
    step_oob = step_dec ? (arg_ext > addr_ext) : (sum_w >= DEPTH_W);
    step_err = step_oob & ~WRAP;
    cnt_inc  = cnt_q + (ADDR_W+1)'(1);
    if (!step_oob) begin
      step_res = step_dec ? (addr_q - step_arg) : sum_w[ADDR_W-1:0];
    end else if (WRAP) begin
      // Operands are below DEPTH, so one add/subtract of DEPTH lands in range.
      step_res = step_dec ? ADDR_W'(addr_ext + DEPTH_W - arg_ext)
                          : ADDR_W'(sum_w - DEPTH_W);
    end else begin
      step_res = step_dec ? '0 : LAST;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    done_d  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_NOP: done_d = 1'b1;
            OP_INC, OP_DEC: begin
              done_d = 1'b1;
              if (arg_big) begin
                err_set = 1'b1;
              end else begin
                addr_d  = step_res;
                err_set = step_err;
              end
            end
            OP_LOAD: begin
              done_d = 1'b1;
              if (arg_big) err_set = 1'b1;
              else         addr_d  = cmd_arg;
            end
            OP_CLEAR: begin
              done_d = 1'b1;
              addr_d = '0;
            end
            OP_SCAN_R, OP_SCAN_L: begin
              state_d = ST_SCAN;
              cnt_d   = '0;
              left_d  = (cmd_op == OP_SCAN_L);
            end
            default: begin
              done_d  = 1'b1;
              err_set = 1'b1;
            end
          endcase
        end
      end
      ST_SCAN: begin
        if (mem_rd_ack) begin
          if (mem_rd_data == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (step_err) begin
            // Saturating mode: stop on the boundary cell.
            done_d  = 1'b1;
            err_set = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d = step_res;
            cnt_d  = cnt_inc;
            // A full lap in wrapping mode means no zero cell exists.
            if (cnt_inc == DEPTH_W) begin
              done_d  = 1'b1;
              err_set = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign mem_rd_req = (state_q == ST_SCAN);
  assign addr       = addr_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bf_pointer_unit.sv
// Directed bench for bf_pointer_unit: four instances cover modulo 1024/1000,
// saturating 1000 and a 16-cell wrapping configuration.
module tb_bf_pointer_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] valid   = '0;
  logic [3:0] err_clr = '0;
  logic [3:0] ack_en  = 4'hF;
  logic       ack_force = 1'b0;
  logic [2:0] op_v  [4];
  logic [9:0] arg_v [4];

  logic [3:0] ready, req, done, err;
  logic [3:0] ack;
  logic [9:0] addr_a, addr_b, addr_c;
  logic [3:0] addr_d;
  logic [7:0] data_a, data_b, data_c, data_d;
  logic [7:0] mem [1024];

  int checks   = 0;
  int failures = 0;
  int ack_cnt  [4] = '{0, 0, 0, 0};
  int done_cnt [4] = '{0, 0, 0, 0};

  // Same-cycle memory: ack follows the request; unit 0 can also see a stray ack.
  assign ack    = (req & ack_en) | {3'b000, ack_force};
  assign data_a = mem[addr_a];
  assign data_b = mem[addr_b];
  assign data_c = mem[addr_c];
  assign data_d = {4'b0000, addr_d} + 8'd1;

  bf_pointer_unit #(.ADDR_W(10), .DEPTH(1024), .DATA_W(8), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_op(op_v[0]), .cmd_arg(arg_v[0]), .addr(addr_a), .mem_rd_req(req[0]),
    .mem_rd_ack(ack[0]), .mem_rd_data(data_a), .done(done[0]), .err(err[0]),
    .err_clr(err_clr[0]));

  bf_pointer_unit #(.ADDR_W(10), .DEPTH(1000), .DATA_W(8), .WRAP(1)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_op(op_v[1]), .cmd_arg(arg_v[1]), .addr(addr_b), .mem_rd_req(req[1]),
    .mem_rd_ack(ack[1]), .mem_rd_data(data_b), .done(done[1]), .err(err[1]),
    .err_clr(err_clr[1]));

  bf_pointer_unit #(.ADDR_W(10), .DEPTH(1000), .DATA_W(8), .WRAP(0)) u_c (
    .clk(clk), .rst(rst), .cmd_valid(valid[2]), .cmd_ready(ready[2]),
    .cmd_op(op_v[2]), .cmd_arg(arg_v[2]), .addr(addr_c), .mem_rd_req(req[2]),
    .mem_rd_ack(ack[2]), .mem_rd_data(data_c), .done(done[2]), .err(err[2]),
    .err_clr(err_clr[2]));

  bf_pointer_unit #(.ADDR_W(4), .DEPTH(16), .DATA_W(8), .WRAP(1)) u_d (
    .clk(clk), .rst(rst), .cmd_valid(valid[3]), .cmd_ready(ready[3]),
    .cmd_op(op_v[3]), .cmd_arg(arg_v[3][3:0]), .addr(addr_d), .mem_rd_req(req[3]),
    .mem_rd_ack(ack[3]), .mem_rd_data(data_d), .done(done[3]), .err(err[3]),
    .err_clr(err_clr[3]));

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (req[i] && ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
      if (done[i])          done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  function automatic logic [9:0] get_addr(input int u);
    case (u)
      0:       return addr_a;
      1:       return addr_b;
      2:       return addr_c;
      default: return {6'b0, addr_d};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one command; returns at the negedge after the accepting edge.
  task automatic cmd(input int u, input logic [2:0] o, input logic [9:0] a);
    valid[u] = 1'b1;
    op_v[u]  = o;
    arg_v[u] = a;
    @(negedge clk);
    valid[u] = 1'b0;
    $display("cmd unit=%0d op=%0d arg=%0d -> addr=%0d done=%0b err=%0b ready=%0b",
             u, o, a, get_addr(u), done[u], err[u], ready[u]);
  endtask

  task automatic run_scan(input int u, input int max, output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!done[u] && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (!done[u] && ready[u]) rdy_seen = 1'b1;
    end
    $display("scan unit=%0d cycles=%0d addr=%0d done=%0b err=%0b", u, cyc, get_addr(u), done[u], err[u]);
  endtask

  int   cyc, acks0, dn0;
  logic rdy_seen;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h55;
    mem[10] = 8'd7; mem[11] = 8'd3; mem[12] = 8'd0;
    for (int i = 0; i < 4; i++) begin op_v[i] = 3'd0; arg_v[i] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_addr", addr_a, 0);
    check("rst_ready", ready, 4'hF);
    check("rst_req", req, 4'h0);
    check("rst_done", done, 4'h0);
    check("rst_err", err, 4'h0);

    // Back-to-back INC/DEC on DEPTH=1024
    valid[0] = 1'b1; op_v[0] = 3'd1; arg_v[0] = 10'd5;
    @(negedge clk);
    check("inc5_addr", addr_a, 5); check("inc5_done", done[0], 1); check("inc5_ready", ready[0], 1);
    op_v[0] = 3'd2; arg_v[0] = 10'd2;
    @(negedge clk);
    valid[0] = 1'b0;
    check("dec2_addr", addr_a, 3); check("dec2_done", done[0], 1); check("dec2_ready", ready[0], 1);
    @(negedge clk);
    check("idle_done", done[0], 0);

    cmd(0, 3'd3, 10'd1020); check("a_load1020", addr_a, 1020);
    cmd(0, 3'd1, 10'd10);   check("a_inc_wrap", addr_a, 6);  check("a_inc_wrap_err", err[0], 0);
    cmd(0, 3'd2, 10'd7);    check("a_dec_wrap", addr_a, 1023);
    cmd(0, 3'd3, 10'd10);

    // SCAN_R over 7,3,0
    acks0 = ack_cnt[0];
    cmd(0, 3'd5, 10'd0);
    check("scanr_ready_low", ready[0], 0); check("scanr_req", req[0], 1);
    check("scanr_nodone", done[0], 0);
    run_scan(0, 20, cyc, rdy_seen);
    check("scanr_done", done[0], 1); check("scanr_cycles", cyc, 3);
    check("scanr_addr", addr_a, 12); check("scanr_acks", ack_cnt[0] - acks0, 3);
    check("scanr_rdy_seen", rdy_seen, 0); check("scanr_err", err[0], 0);
    check("scanr_ready_back", ready[0], 1); check("scanr_req_off", req[0], 0);

    // Reserved op, err_clr collision, stray ack
    cmd(0, 3'd7, 10'd0);
    check("rsv_err", err[0], 1); check("rsv_done", done[0], 1); check("rsv_addr", addr_a, 12);
    err_clr[0] = 1'b1;
    cmd(0, 3'd7, 10'd0);
    err_clr[0] = 1'b0;
    check("clr_vs_set", err[0], 1);
    err_clr[0] = 1'b1; @(negedge clk); err_clr[0] = 1'b0;
    check("a_errclr", err[0], 0);
    ack_force = 1'b1; @(negedge clk); ack_force = 1'b0;
    check("stray_ack_addr", addr_a, 12); check("stray_ack_done", done[0], 0);
    check("stray_ack_ready", ready[0], 1);
    cmd(0, 3'd4, 10'd9); check("clear_addr", addr_a, 0); check("clear_done", done[0], 1);
    cmd(0, 3'd0, 10'd9); check("nop_addr", addr_a, 0); check("nop_done", done[0], 1);

    // WRAP=1, DEPTH=1000
    cmd(1, 3'd3, 10'd998); check("b_load", addr_b, 998);
    cmd(1, 3'd1, 10'd5);   check("b_inc_wrap", addr_b, 3);   check("b_inc_err", err[1], 0);
    cmd(1, 3'd2, 10'd4);   check("b_dec_wrap", addr_b, 999); check("b_dec_err", err[1], 0);
    cmd(1, 3'd1, 10'd0);   check("b_inc0", addr_b, 999); check("b_inc0_err", err[1], 0);
    check("b_inc0_done", done[1], 1);
    cmd(1, 3'd1, 10'd1000); check("b_argbig_addr", addr_b, 999);
    check("b_argbig_err", err[1], 1); check("b_argbig_done", done[1], 1);

    // WRAP=0, DEPTH=1000
    cmd(2, 3'd3, 10'd998); check("c_load", addr_c, 998);
    cmd(2, 3'd1, 10'd5);   check("c_inc_clamp", addr_c, 999); check("c_clamp_err", err[2], 1);
    cmd(2, 3'd3, 10'd1000); check("c_load_oob", addr_c, 999);
    err_clr[2] = 1'b1; @(negedge clk); err_clr[2] = 1'b0;
    check("c_errclr", err[2], 0);
    cmd(2, 3'd3, 10'd5);
    cmd(2, 3'd2, 10'd9);   check("c_dec_clamp", addr_c, 0); check("c_dec_err", err[2], 1);
    err_clr[2] = 1'b1; @(negedge clk); err_clr[2] = 1'b0;
    cmd(2, 3'd3, 10'd2);
    acks0 = ack_cnt[2];
    cmd(2, 3'd6, 10'd0);
    run_scan(2, 20, cyc, rdy_seen);
    check("c_scanl_done", done[2], 1); check("c_scanl_addr", addr_c, 0);
    check("c_scanl_err", err[2], 1); check("c_scanl_acks", ack_cnt[2] - acks0, 3);

    // WRAP=1, DEPTH=16, no zero cell
    cmd(3, 3'd3, 10'd5);
    acks0 = ack_cnt[3];
    cmd(3, 3'd6, 10'd0);
    run_scan(3, 40, cyc, rdy_seen);
    check("d_scan_done", done[3], 1); check("d_scan_acks", ack_cnt[3] - acks0, 16);
    check("d_scan_cycles", cyc, 16); check("d_scan_err", err[3], 1);
    check("d_scan_addr", addr_d, 5); check("d_scan_rdy_seen", rdy_seen, 0);
    cmd(3, 3'd2, 10'd7); check("d_dec_wrap", addr_d, 14);

    // Reset in the middle of a scan
    cmd(0, 3'd3, 10'd20); check("a_load20", addr_a, 20);
    acks0 = ack_cnt[0];
    cmd(0, 3'd5, 10'd0);
    repeat (2) @(negedge clk);
    check("mid_scan_addr", addr_a, 22); check("mid_scan_acks", ack_cnt[0] - acks0, 2);
    dn0 = done_cnt[0];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_scan_addr", addr_a, 0); check("rst_scan_req", req[0], 0);
    check("rst_scan_ready", ready[0], 1); check("rst_scan_done", done[0], 0);
    @(negedge clk);
    check("rst_scan_nodone", done_cnt[0] - dn0, 0);
    cmd(0, 3'd1, 10'd1); check("post_rst_inc", addr_a, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf_pointer_unit.md
# bf_pointer_unit

Parametrised data-pointer unit for the brainfuck core. It holds the data-memory address and executes run-length-compressed pointer moves (`>`×k, `<`×k), direct load and clear. It also executes the `[>]` / `[<]` scan idioms by reading data memory until it finds a zero cell. It sits between the instruction decoder (command handshake) and the data-memory read port, and supersedes the fixed 10-bit increment/decrement pointer.

## Interface
Parameters:
- ADDR_W, 10, pointer and argument width
- DEPTH, 1024, number of data cells; legal range 2..2**ADDR_W; pointer range 0..DEPTH-1
- DATA_W, 8, data-memory word width
- WRAP, 1, 1 = modulo-DEPTH arithmetic, 0 = saturate at 0 / DEPTH-1

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  unit can accept a command
- cmd_op  in  3  0 NOP, 1 INC, 2 DEC, 3 LOAD, 4 CLEAR, 5 SCAN_R, 6 SCAN_L, 7 reserved
- cmd_arg  in  ADDR_W  step count (INC/DEC) or target address (LOAD); ignored otherwise
- addr  out  ADDR_W  current pointer, registered
- mem_rd_req  out  1  read request for cell `addr` (scan only)
- mem_rd_ack  in  1  read data valid this cycle
- mem_rd_data  in  DATA_W  cell value, sampled when mem_rd_ack=1
- done  out  1  one-cycle pulse: command completed
- err  out  1  sticky error flag
- err_clr  in  1  clears err

## Operation
- A command is accepted on the rising edge where cmd_valid & cmd_ready = 1.
- States: IDLE, SCAN.
- In IDLE, cmd_ready=1 and mem_rd_req=0.
- INC: next = addr + arg.
  - WRAP=1: result reduced modulo DEPTH (compute in ADDR_W+1 bits, subtract DEPTH if ≥ DEPTH).
  - WRAP=0: clamp to DEPTH-1; err set if clamped.
- DEC: next = addr − arg.
  - WRAP=1: add DEPTH if negative.
  - WRAP=0: clamp to 0; err set if clamped.
- INC/DEC with arg ≥ DEPTH: addr unchanged, err set, done still pulses.
- INC/DEC with arg = 0: addr unchanged, no error.
- LOAD: addr ← arg if arg < DEPTH; otherwise addr unchanged and err set.
- CLEAR: addr ← 0.
- NOP: no change.
- Reserved op (7): no change, err set.
- All of the ops above (NOP through CLEAR, plus reserved) complete in IDLE; the unit stays in IDLE.
- SCAN_R / SCAN_L:
  - Go to SCAN and clear the iteration counter (ADDR_W+1 bits).
  - In SCAN: cmd_ready=0, mem_rd_req=1 with address = addr.
  - On mem_rd_ack with data = 0: done, return to IDLE; addr stays on the zero cell.
  - On mem_rd_ack with data ≠ 0: step addr by ±1 under the same WRAP rules and increment the counter.
  - WRAP=0, at the boundary (DEPTH-1 for R, 0 for L) with nonzero data: err, done, return to IDLE; addr stays at the boundary.
  - WRAP=1, counter reaches DEPTH with no zero found: err, done, return to IDLE.
- mem_rd_ack while mem_rd_req=0 is ignored.
- err_clr clears err. If err_clr coincides with a new error event, set wins.

## Timing
- Values after rst: addr=0, cmd_ready=1, mem_rd_req=0, done=0, err=0, state IDLE, counter 0.
- Reset in SCAN aborts the scan with no done pulse.
- rst has priority over all inputs.
- Simple ops: addr and done are updated on the accepting edge, so they are visible the cycle after the handshake. cmd_ready stays 1, giving one command per cycle back-to-back.
- Scan:
  - On the accepting edge, cmd_ready falls and mem_rd_req rises.
  - Each ack with nonzero data moves addr on that edge. mem_rd_req stays high, so the request for the new address is presented the following cycle.
  - Latency is N+1 cycles minimum for N reads with a 1-cycle ack. Memory wait states stretch it.
  - On the terminating ack edge: done=1, mem_rd_req=0, cmd_ready=1 (visible the next cycle).
  - A new command can be accepted the cycle done is high.
- done is high for exactly one cycle per accepted command; never high without a command.

## Test plan
- Reset then INC arg=5, DEC arg=2 back-to-back (DEPTH=1024) -> addr 5 then 3; done high two consecutive cycles; cmd_ready never low.
- WRAP=1, DEPTH=1000: LOAD 998, INC 5 -> addr 3, err=0. Then DEC 4 -> addr 999.
- WRAP=0, DEPTH=1000: LOAD 998, INC 5 -> addr 999, err=1. Then LOAD 1000 -> addr unchanged. err_clr -> err=0.
- SCAN_R from addr 10, memory cells 10..12 = 7,3,0, ack 1 cycle after req -> addr 12, done after 3 acks, cmd_ready low throughout, err=0.
- WRAP=1, DEPTH=16, all cells nonzero, SCAN_L -> exactly 16 acks consumed, then err=1 and done; addr back at start value. WRAP=0 variant from addr 2 -> stops at 0 with err.
- Assert rst during SCAN after 2 acks -> next cycle addr=0, mem_rd_req=0, cmd_ready=1, no done pulse; INC 1 next -> addr 1.
